// File: rtl/inst_encoder.sv
// RV32 instruction word encoder for the R, I, S and B formats, with immediate
// range/alignment checking, an output FIFO and a saturating error counter.
module inst_encoder #(
    parameter int FIFO_DEPTH = 2,
    parameter int ERRCNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_ops,
    input  logic [6:0]          in_opcode,
    input  logic [4:0]          in_rd,
    input  logic [4:0]          in_rs1,
    input  logic [4:0]          in_rs2,
    input  logic [2:0]          in_funct3,
    input  logic [6:0]          in_funct7,
    input  logic [31:0]         in_imm,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_inst,
    output logic                out_err,
    output logic [ERRCNT_W-1:0] err_cnt
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // in_ready depends only on the registered FIFO count, never on out_ready.

    localparam logic [1:0] EXTNR_R = 2'd0;
    localparam logic [1:0] EXTNR_I = 2'd1;
    localparam logic [1:0] EXTNR_S = 2'd2;
    localparam logic [1:0] EXTNR_B = 2'd3;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   enc_inst;
    logic          enc_err;
    logic          fit12;
    logic          fit13_even;
    logic          push;
    logic          pop;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [32:0]   mem [FIFO_DEPTH];
    logic [32:0]   head;

    // An immediate fits in N signed bits when every bit above N-1 equals the sign bit.
    assign fit12      = (in_imm[31:11] == {21{in_imm[11]}});
    assign fit13_even = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];

    always_comb begin
        enc_inst = '0;
        enc_err  = 1'b0;
        case (in_ops)
            EXTNR_I: begin
                enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                enc_err  = !fit12;
            end
            EXTNR_S: begin
                enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                enc_err  = !fit12;
            end
            EXTNR_B: begin
                enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
                enc_err  = !fit13_even;
            end
            default: begin
                enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                enc_err  = 1'b0;
            end
        endcase
    end

    assign in_ready  = (count != CW'(FIFO_DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign head     = mem[rd_ptr];
    assign out_inst = out_valid ? head[31:0] : '0;
    assign out_err  = out_valid ? head[32] : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && enc_err && (err_cnt != {ERRCNT_W{1'b1}})) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    // Storage needs no reset: out_inst/out_err are masked while the count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {enc_err, enc_inst};
        end
    end

endmodule
